// File: rtl/initial_logic_nvc.sv
// Transaction-layer ingress: each written word is steered by its class field into one of NUM_VC FIFOs.
// Define ERROR_STICKY_EN to latch error[v] until reset; otherwise error[v] pulses once per offending cycle.
module initial_logic_nvc #(
    parameter int DATA_WIDTH = 6,
    parameter int NUM_VC     = 2,
    parameter int ADDR_WIDTH = 2,
    parameter int AFULL_LVL  = 3,
    parameter int AEMPTY_LVL = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_enable,
    input  logic [DATA_WIDTH-1:0]        data_in,
    input  logic [NUM_VC-1:0]            pop,
    output logic [NUM_VC-1:0]            full,
    output logic [NUM_VC-1:0]            empty,
    output logic [NUM_VC-1:0]            almost_full,
    output logic [NUM_VC-1:0]            almost_empty,
    output logic [NUM_VC-1:0]            error,
    output logic [NUM_VC*DATA_WIDTH-1:0] data_out
);

    localparam int DEPTH    = 2 ** ADDR_WIDTH;
    localparam int CNT_W    = ADDR_WIDTH + 1;
    localparam int VC_SEL_W = (NUM_VC > 1) ? $clog2(NUM_VC) : 0;
    localparam int TGT_W    = (VC_SEL_W > 0) ? VC_SEL_W : 1;

    logic [TGT_W-1:0] target_vc;

    // A single-VC build has no class field, so every write goes to VC 0.
    generate
        if (VC_SEL_W > 0) begin : g_sel
            assign target_vc = data_in[DATA_WIDTH-1 -: TGT_W];
        end else begin : g_nosel
            assign target_vc = '0;
        end
    endgenerate

    generate
        for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
            logic [DATA_WIDTH-1:0] mem [DEPTH];
            logic [ADDR_WIDTH-1:0] wr_ptr;
            logic [ADDR_WIDTH-1:0] rd_ptr;
            logic [CNT_W-1:0]      count;
            logic [DATA_WIDTH-1:0] dout_q;
            logic                  err_q;
            logic                  push_req;
            logic                  is_full;
            logic                  is_empty;
            logic                  do_push;
            logic                  do_pop;
            logic                  fault;

            assign push_req = wr_enable && (target_vc == TGT_W'(v));
            assign is_full  = (count == CNT_W'(DEPTH));
            assign is_empty = (count == '0);
            assign do_pop   = pop[v] && !is_empty;
            // A pop on a full VC frees the slot the same-cycle push lands in.
            assign do_push  = push_req && (!is_full || do_pop);
            assign fault    = (push_req && !do_push) || (pop[v] && is_empty);

            always_ff @(posedge clk) begin
                if (do_push) begin
                    mem[wr_ptr] <= data_in;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                    count  <= '0;
                    dout_q <= '0;
                    err_q  <= 1'b0;
                end else begin
                    if (do_push) begin
                        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
                    end
                    if (do_pop) begin
                        rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
                        dout_q <= mem[rd_ptr];
                    end
                    if (do_push && !do_pop) begin
                        count <= count + CNT_W'(1);
                    end else if (do_pop && !do_push) begin
                        count <= count - CNT_W'(1);
                    end
`ifdef ERROR_STICKY_EN
                    err_q <= err_q | fault;
`else
                    err_q <= fault;
`endif
                end
            end

            assign full[v]         = is_full;
            assign empty[v]        = is_empty;
            assign almost_full[v]  = (count >= CNT_W'(AFULL_LVL));
            assign almost_empty[v] = (count <= CNT_W'(AEMPTY_LVL));
            assign error[v]        = err_q;
            assign data_out[v*DATA_WIDTH +: DATA_WIDTH] = dout_q;
        end
    endgenerate

endmodule

// File: tb/tb_initial_logic_nvc.sv
// Self-checking bench for initial_logic_nvc (2 VCs, 6-bit words, depth 4) using a queue model
// and a scoreboard of expected popped words.
module tb_initial_logic_nvc;

    logic        clk;
    logic        reset;
    logic        wr_enable;
    logic [5:0]  data_in;
    logic [1:0]  pop;
    logic [1:0]  full;
    logic [1:0]  empty;
    logic [1:0]  almost_full;
    logic [1:0]  almost_empty;
    logic [1:0]  error;
    logic [11:0] data_out;

    typedef struct {
        int         vc;
        logic [5:0] data;
    } sb_t;

    sb_t        sb_q [$];
    logic [5:0] model_q [2][$];
    logic [5:0] dout_m [2];
    logic       err_m [2];
    int         checks;
    int         passes;

    initial_logic_nvc #(
        .DATA_WIDTH(6),
        .NUM_VC(2),
        .ADDR_WIDTH(2),
        .AFULL_LVL(3),
        .AEMPTY_LVL(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .wr_enable(wr_enable),
        .data_in(data_in),
        .pop(pop),
        .full(full),
        .empty(empty),
        .almost_full(almost_full),
        .almost_empty(almost_empty),
        .error(error),
        .data_out(data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Compares every output against the model; popped words come from the scoreboard.
    task automatic checkState();
        logic [1:0] exp_empty, exp_full, exp_af, exp_ae, exp_err;
        sb_t s;
        while (sb_q.size() > 0) begin
            s = sb_q.pop_front();
            checkOutput($sformatf("pop_data_vc%0d", s.vc), 32'(data_out[s.vc*6 +: 6]), 32'(s.data));
        end
        for (int v = 0; v < 2; v++) begin
            exp_empty[v] = (model_q[v].size() == 0);
            exp_full[v]  = (model_q[v].size() == 4);
            exp_af[v]    = (model_q[v].size() >= 3);
            exp_ae[v]    = (model_q[v].size() <= 1);
            exp_err[v]   = err_m[v];
        end
        checkOutput("empty", 32'(empty), 32'(exp_empty));
        checkOutput("full", 32'(full), 32'(exp_full));
        checkOutput("almost_full", 32'(almost_full), 32'(exp_af));
        checkOutput("almost_empty", 32'(almost_empty), 32'(exp_ae));
        checkOutput("error", 32'(error), 32'(exp_err));
        checkOutput("data_out", 32'(data_out), 32'({dout_m[1], dout_m[0]}));
    endtask

    task automatic doReset(input int cycles);
        reset = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        for (int v = 0; v < 2; v++) begin
            model_q[v].delete();
            dout_m[v] = '0;
            err_m[v]  = 1'b0;
        end
        sb_q.delete();
        checkState();
    endtask

    // Drives one cycle, advances the model and scoreboard, then checks after the edge.
    task automatic applyStimulus(input logic we, input logic [5:0] din, input logic [1:0] p);
        logic push_req, can_pop, can_push, fault;
        sb_t s;
        wr_enable = we;
        data_in   = din;
        pop       = p;
        for (int v = 0; v < 2; v++) begin
            push_req = we && (int'(din[5]) == v);
            can_pop  = p[v] && (model_q[v].size() > 0);
            can_push = push_req && ((model_q[v].size() < 4) || can_pop);
            fault    = (push_req && !can_push) || (p[v] && (model_q[v].size() == 0));
            if (can_pop) begin
                dout_m[v] = model_q[v].pop_front();
                s.vc   = v;
                s.data = dout_m[v];
                sb_q.push_back(s);
            end
            if (can_push) begin
                model_q[v].push_back(din);
            end
`ifdef ERROR_STICKY_EN
            err_m[v] = err_m[v] | fault;
`else
            err_m[v] = fault;
`endif
        end
        @(posedge clk);
        #1;
        wr_enable = 1'b0;
        pop       = 2'b00;
        checkState();
    endtask

    initial begin
        checks    = 0;
        passes    = 0;
        reset     = 1'b1;
        wr_enable = 1'b0;
        data_in   = '0;
        pop       = 2'b00;

        doReset(2);
        checkOutput("reset_empty_const", 32'(empty), 32'h3);

        applyStimulus(1'b1, 6'h25, 2'b00);
        applyStimulus(1'b1, 6'h0A, 2'b00);
        applyStimulus(1'b0, 6'h00, 2'b11);
        checkOutput("t2_vc0", 32'(data_out[5:0]), 32'h0A);
        checkOutput("t2_vc1", 32'(data_out[11:6]), 32'h25);

        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, 6'(i), 2'b00);
        end
        checkOutput("t3_full0", 32'(full[0]), 32'h1);
        applyStimulus(1'b1, 6'h05, 2'b00);
        checkOutput("t3_overflow_err", 32'(error[0]), 32'h1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 6'h00, 2'b01);
        end

        applyStimulus(1'b0, 6'h00, 2'b10);
        checkOutput("t4_underflow_err", 32'(error[1]), 32'h1);

        doReset(1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 6'h11 + 6'(i), 2'b00);
        end
        applyStimulus(1'b1, 6'h07, 2'b01);
        checkOutput("t5_oldest", 32'(data_out[5:0]), 32'h11);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 6'h00, 2'b01);
        end
        checkOutput("t5_last", 32'(data_out[5:0]), 32'h07);

        applyStimulus(1'b1, 6'h03, 2'b01);
        applyStimulus(1'b1, 6'h2B, 2'b00);
        applyStimulus(1'b1, 6'h2C, 2'b00);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 6'h08 + 6'(i), 2'b00);
        end
        wr_enable = 1'b1;
        data_in   = 6'h0F;
        doReset(1);
        wr_enable = 1'b0;
        applyStimulus(1'b0, 6'h00, 2'b01);
        checkOutput("t6_err_after_reset", 32'(error[0]), 32'h1);
        applyStimulus(1'b0, 6'h00, 2'b00);
        applyStimulus(1'b0, 6'h00, 2'b00);

        doReset(1);
        for (int i = 0; i < 60; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 6'($urandom), 2'($urandom));
        end

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
